// File: rtl/mp_core_arbiter.sv
// Four-core round-robin arbiter feeding a single registered output slot.
// Define ARB_BURST_LOCK_EN to keep the pointer on a core for up to 4 back-to-back grants.
module mp_core_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                req,
  input  logic [15:0]               opcode_in,
  input  logic [4*DATA_WIDTH-1:0]   a_in,
  input  logic [4*DATA_WIDTH-1:0]   b_in,
  input  logic [4*ADDR_WIDTH-1:0]   addr_in,
  input  logic [3:0]                we_in,
  input  logic [3:0]                read_en_in,
  output logic [3:0]                gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                core_id,
  output logic [3:0]                opcode,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic                      we,
  output logic                      read_en,
  output logic [31:0]               burst_id
);

  logic                  r_valid;
  logic [1:0]            r_core;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic                  r_rd;
  logic [31:0]           r_bid;
  logic [31:0]           r_txn_cnt;
  logic [1:0]            r_ptr;

  logic                  w_free;
  logic                  w_hit;
  logic [1:0]            w_win;
  logic                  w_grant;
  logic [1:0]            w_ptr_nxt;

`ifdef ARB_BURST_LOCK_EN
  logic [1:0]            r_beat;
  logic [1:0]            w_beat_nxt;
  logic [1:0]            w_run;
`endif

  assign w_free  = ~r_valid | out_ready;
  assign w_grant = w_hit & w_free & ~reset;
  assign gnt     = w_grant ? (4'b0001 << w_win) : 4'b0000;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    w_hit = 1'b0;
    w_win = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = r_ptr + 2'(i);
      if (req[idx]) begin
        w_hit = 1'b1;
        w_win = idx;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
`ifdef ARB_BURST_LOCK_EN
    // r_beat != 0 means r_ptr is a locked core with r_beat grants so far.
    w_beat_nxt = r_beat;
    w_run      = (w_win == r_ptr && r_beat != 2'd0) ? r_beat : 2'd0;
    if (w_grant) begin
      if (w_run == 2'd3) begin
        w_ptr_nxt  = w_win + 2'd1;
        w_beat_nxt = 2'd0;
      end else begin
        w_ptr_nxt  = w_win;
        w_beat_nxt = w_run + 2'd1;
      end
    end else if (w_free && r_beat != 2'd0 && !req[r_ptr]) begin
      w_ptr_nxt  = r_ptr + 2'd1;
      w_beat_nxt = 2'd0;
    end
`else
    if (w_grant) w_ptr_nxt = w_win + 2'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_core    <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_rd      <= 1'b0;
      r_bid     <= '0;
      r_txn_cnt <= '0;
      r_ptr     <= '0;
`ifdef ARB_BURST_LOCK_EN
      r_beat    <= '0;
`endif
    end else begin
      r_ptr <= w_ptr_nxt;
`ifdef ARB_BURST_LOCK_EN
      r_beat <= w_beat_nxt;
`endif
      if (w_grant) begin
        r_valid   <= 1'b1;
        r_core    <= w_win;
        r_op      <= opcode_in[w_win*4 +: 4];
        r_a       <= a_in[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_b       <= b_in[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_addr    <= addr_in[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_we      <= we_in[w_win];
        r_rd      <= read_en_in[w_win];
        r_bid     <= r_txn_cnt;
        r_txn_cnt <= r_txn_cnt + 32'd1;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign core_id   = r_core;
  assign opcode    = r_op;
  assign A         = r_a;
  assign B         = r_b;
  assign addr      = r_addr;
  assign we        = r_we;
  assign read_en   = r_rd;
  assign burst_id  = r_bid;

endmodule

// File: tb/tb_mp_core_arbiter.sv
// Randomized + directed bench for mp_core_arbiter against a behavioural model.
module tb_mp_core_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0]      req;
  logic [15:0]     opcode_in;
  logic [4*DW-1:0] a_in, b_in;
  logic [4*AW-1:0] addr_in;
  logic [3:0]      we_in, read_en_in;
  logic [3:0]      gnt;
  logic            out_valid, out_ready;
  logic [1:0]      core_id;
  logic [3:0]      opcode;
  logic [DW-1:0]   A, B;
  logic [AW-1:0]   addr;
  logic            we, read_en;
  logic [31:0]     burst_id;

  mp_core_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .opcode_in(opcode_in), .a_in(a_in),
    .b_in(b_in), .addr_in(addr_in), .we_in(we_in), .read_en_in(read_en_in),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready), .core_id(core_id),
    .opcode(opcode), .A(A), .B(B), .addr(addr), .we(we), .read_en(read_en),
    .burst_id(burst_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: pointer as an integer, counter, output slot contents.
  int          m_ptr;
  int          m_run;
  logic [31:0] m_cnt;
  logic        m_valid;
  logic [34:0] m_pay;
  logic [31:0] m_bid;

  function automatic logic [34:0] in_pay(input int k);
    return {2'(k), opcode_in[k*4 +: 4], a_in[k*DW +: DW], b_in[k*DW +: DW],
            addr_in[k*AW +: AW], we_in[k], read_en_in[k]};
  endfunction

  function automatic int m_winner();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    for (int i = 0; i < 4; i++)
      if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_run = 0; m_cnt = '0; m_valid = 1'b0; m_pay = '0; m_bid = '0;
  endtask

  // Inputs already driven; checks gnt, clocks once, updates model, checks outputs.
  task automatic step(output int w);
    logic        free;
    logic [34:0] pay;
    #1;
    w    = m_winner();
    free = !m_valid || out_ready;
    pay  = (w >= 0) ? in_pay(w) : '0;
    chk("gnt", {60'd0, gnt}, (w >= 0) ? 64'(1 << w) : 64'd0);
    @(posedge clk);
    if (reset) begin
      m_reset();
    end else if (w >= 0) begin
      m_valid = 1'b1; m_pay = pay; m_bid = m_cnt; m_cnt = m_cnt + 1;
`ifdef ARB_BURST_LOCK_EN
      m_run = (m_run > 0 && w == m_ptr) ? m_run + 1 : 1;
      if (m_run == 4) begin m_ptr = (w + 1) % 4; m_run = 0; end
      else m_ptr = w;
`else
      m_ptr = (w + 1) % 4;
`endif
    end else if (free) begin
      m_valid = 1'b0;
`ifdef ARB_BURST_LOCK_EN
      if (m_run > 0 && !req[m_ptr]) begin m_ptr = (m_ptr + 1) % 4; m_run = 0; end
`endif
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("payload", {29'd0, core_id, opcode, A, B, addr, we, read_en}, {29'd0, m_pay});
    chk("burst_id", {32'd0, burst_id}, {32'd0, m_bid});
    #1;
  endtask

  task automatic set_core(input int k, input logic r);
    req[k]                  = r;
    opcode_in[k*4 +: 4]     = 4'($urandom);
    a_in[k*DW +: DW]        = DW'($urandom);
    b_in[k*DW +: DW]        = DW'($urandom);
    addr_in[k*AW +: AW]     = AW'($urandom);
    we_in[k]                = 1'($urandom);
    read_en_in[k]           = 1'($urandom);
  endtask

  task automatic do_reset();
    int w;
    reset = 1'b1; req = '0; out_ready = 1'b0;
    step(w);
    reset = 1'b0;
  endtask

  initial begin
    int w;
    logic [34:0] held;
    reset = 1'b1; req = '0; out_ready = 1'b0;
    opcode_in = '0; a_in = '0; b_in = '0; addr_in = '0; we_in = '0; read_en_in = '0;
    m_reset();
    @(posedge clk); #2;
    do_reset();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_bid", {32'd0, burst_id}, 64'd0);

    // Single core
    set_core(0, 1'b1);
    a_in[0 +: DW] = 8'h12; b_in[0 +: DW] = 8'h34; addr_in[0 +: AW] = 11'h7FF;
    out_ready = 1'b1;
    step(w);
    chk("single_win", 64'(w), 64'd0);
    chk("single_A", {56'd0, A}, 64'h12);
    chk("single_B", {56'd0, B}, 64'h34);
    chk("single_addr", {53'd0, addr}, 64'h7FF);
    chk("single_core", {62'd0, core_id}, 64'd0);
    req = '0;

    // Backpressure
    do_reset();
    out_ready = 1'b1; set_core(0, 1'b1);
    step(w);
    held = {core_id, opcode, A, B, addr, we, read_en};
    req = '0; set_core(2, 1'b1); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(w);
      chk("bp_gnt", {60'd0, gnt}, 64'd0);
      chk("bp_hold", {29'd0, core_id, opcode, A, B, addr, we, read_en}, {29'd0, held});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", {60'd0, gnt}, 64'h4);
    step(w);
    req = '0;

    // Reset mid-operation
    do_reset();
    out_ready = 1'b1; set_core(0, 1'b1);
    step(w);
    req = '0; set_core(3, 1'b1); out_ready = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_gnt", {60'd0, gnt}, 64'd0);
    step(w);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    step(w);
    chk("midrst_win", 64'(w), 64'd3);
    chk("midrst_bid", {32'd0, burst_id}, 64'd0);
    req = '0;

`ifdef ARB_BURST_LOCK_EN
    begin
      int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      do_reset();
      out_ready = 1'b1; set_core(0, 1'b1); set_core(1, 1'b1);
      for (int i = 0; i < 9; i++) begin
        step(w);
        chk("burst_order", 64'(w), 64'(exp_seq[i]));
        if (w >= 0) set_core(w, 1'b1);
      end
      req = '0;
    end
`else
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_core(k, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(w);
      chk("rr_order", 64'(w), 64'(i % 4));
      chk("rr_bid", {32'd0, burst_id}, 64'(i));
      if (w >= 0) set_core(w, 1'b1);
    end
    req = '0;
`endif

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_core(k, 1'b1);
    force dut.r_txn_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_txn_cnt;
    m_cnt = 32'hFFFF_FFFF;
    step(w);
    chk("wrap_bid0", {32'd0, burst_id}, 64'hFFFF_FFFF);
    if (w >= 0) set_core(w, 1'b1);
    step(w);
    chk("wrap_bid1", {32'd0, burst_id}, 64'h0);
    req = '0;

    // Randomized traffic honouring the hold-until-granted rule
    do_reset();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 59) == 0);
      step(w);
      for (int k = 0; k < 4; k++)
        if (w == k || !req[k]) set_core(k, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
